// File: rtl/bcd_lap_stopwatch_if.sv
// Control levels from the debouncers and display/status outputs of the BCD lap stopwatch.
interface bcd_lap_stopwatch_if #(
  parameter int NUM_DIGITS = 8
);
  logic                  startIn;
  logic                  clearIn;
  logic                  lapIn;
  logic                  modeIn;
  logic [NUM_DIGITS-1:0] anOut;
  logic [6:0]            segOut;
  logic                  runningOut;
  logic                  lapOut;
  logic                  doneOut;

  modport master (
    output startIn, clearIn, lapIn, modeIn,
    input  anOut, segOut, runningOut, lapOut, doneOut
  );

  modport slave (
    input  startIn, clearIn, lapIn, modeIn,
    output anOut, segOut, runningOut, lapOut, doneOut
  );
endinterface

// File: rtl/bcd_lap_stopwatch.sv
// Stopwatch/timer with a cascaded BCD digit chain, count-down, lap capture and
// a multiplexed active-low 7-segment display.
module bcd_lap_stopwatch #(
  parameter int          NUM_DIGITS = 8,
  parameter int          TICK_DIV   = 1000000,
  parameter int          SCAN_DIV   = 100000,
  parameter bit          WRAP       = 1'b1,
  parameter logic [31:0] PRESET     = 32'h0000_3000
) (
  input logic               clkIn,
  input logic               rstW,
  bcd_lap_stopwatch_if.slave sw
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0][3:0] PRESET_D = PRESET[4*NUM_DIGITS-1:0];
  localparam logic [NUM_DIGITS-1:0][3:0] ONE_D    = (4*NUM_DIGITS)'(1);

  typedef enum logic {ST_STOP, ST_RUN} runState_t;

  runState_t                   runState;
  logic                        modeDown, lapOn, doneReg, primed;
  logic                        startPrev, clearPrev, lapPrev;
  logic [PW-1:0]               presc;
  logic [NUM_DIGITS-1:0][3:0]  digits, lapDigits, upNext, dnNext;
  logic                        upCarry, dnBorrow;
  logic [SW-1:0]               slot;
  logic [IW-1:0]               scanIdx;
  logic [NUM_DIGITS-1:0]       anReg;
  logic [6:0]                  segReg;
  logic [3:0]                  shownDigit;
  logic                        startEvt, clearEvt, lapEvt, tick, startBlocked;

  function automatic logic [3:0] digitMax(int unsigned k);
    return (k == 3 || k == 5) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [6:0] seg7(logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // primed masks the first cycle after reset so levels already high never fire
  assign startEvt = sw.startIn & ~startPrev & primed;
  assign clearEvt = sw.clearIn & ~clearPrev & primed;
  assign lapEvt   = sw.lapIn   & ~lapPrev   & primed;
  assign tick     = (presc == TICK_LAST);
  assign startBlocked = sw.modeIn && (clearEvt ? (PRESET_D == '0) : (digits == '0));

  // Full-chain ripple resolved combinationally; upCarry out of the top digit means full scale
  always_comb begin
    upNext   = digits;
    dnNext   = digits;
    upCarry  = 1'b1;
    dnBorrow = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (upCarry) begin
        if (digits[k] == digitMax(k)) upNext[k] = '0;
        else begin
          upNext[k] = digits[k] + 4'd1;
          upCarry   = 1'b0;
        end
      end
      if (dnBorrow) begin
        if (digits[k] == 4'd0) dnNext[k] = digitMax(k);
        else begin
          dnNext[k] = digits[k] - 4'd1;
          dnBorrow  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clkIn or posedge rstW) begin
    if (rstW) begin
      runState  <= ST_STOP;
      modeDown  <= 1'b0;
      lapOn     <= 1'b0;
      doneReg   <= 1'b0;
      primed    <= 1'b0;
      startPrev <= 1'b0;
      clearPrev <= 1'b0;
      lapPrev   <= 1'b0;
      presc     <= '0;
      digits    <= '0;
      lapDigits <= '0;
    end else begin
      primed    <= 1'b1;
      startPrev <= sw.startIn;
      clearPrev <= sw.clearIn;
      lapPrev   <= sw.lapIn;
      doneReg   <= 1'b0;
      case (runState)
        ST_RUN: begin
          if (tick) begin
            presc <= '0;
            if (modeDown) begin
              digits <= dnNext;
              if (digits == ONE_D) begin
                runState <= ST_STOP;
                doneReg  <= 1'b1;
              end
            end else if (upCarry && !WRAP) begin
              runState <= ST_STOP;
              doneReg  <= 1'b1;
            end else begin
              digits <= upNext;
              if (upCarry) doneReg <= 1'b1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
          if (startEvt) runState <= ST_STOP;
          if (lapEvt) begin
            lapOn <= ~lapOn;
            if (!lapOn) lapDigits <= digits;
          end
        end
        default: begin
          if (clearEvt) begin
            digits <= sw.modeIn ? PRESET_D : '0;
            presc  <= '0;
            lapOn  <= 1'b0;
          end
          if (lapEvt) lapOn <= 1'b0;
          if (startEvt && !startBlocked) begin
            runState <= ST_RUN;
            modeDown <= sw.modeIn;
            presc    <= '0;
          end
        end
      endcase
    end
  end

  assign shownDigit = lapOn ? lapDigits[scanIdx] : digits[scanIdx];

  always_ff @(posedge clkIn or posedge rstW) begin
    if (rstW) begin
      slot    <= '0;
      scanIdx <= '0;
      anReg   <= '1;
      segReg  <= 7'h7F;
    end else begin
      if (slot == SLOT_LAST) begin
        slot    <= '0;
        scanIdx <= (scanIdx == IDX_LAST) ? '0 : scanIdx + IW'(1);
      end else begin
        slot <= slot + SW'(1);
      end
      anReg  <= ~(NUM_DIGITS'(1) << scanIdx);
      segReg <= seg7(shownDigit);
    end
  end

  assign sw.anOut      = anReg;
  assign sw.segOut     = segReg;
  assign sw.runningOut = (runState == ST_RUN);
  assign sw.lapOut     = lapOn;
  assign sw.doneOut    = doneReg;
endmodule

// File: tb/tb_bcd_lap_stopwatch.sv
// Randomized scoreboard bench for bcd_lap_stopwatch: one wrapping and one saturating
// instance checked every cycle against an integer-valued reference model.
module tb_bcd_lap_stopwatch;
  localparam int          ND   = 4;
  localparam int          TD   = 4;
  localparam int          SD   = 2;
  localparam logic [31:0] PRE  = 32'h0000_0003;
  localparam int          PREN = 3;
  localparam int          MODN = 6000;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          run;
    logic          lap;
    logic          done;
  } obs_t;

  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic clkIn = 1'b0;
  logic rstW;
  logic startIn, clearIn, lapIn, modeIn;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clkIn = ~clkIn;

  bcd_lap_stopwatch_if #(.NUM_DIGITS(ND)) ifW ();
  bcd_lap_stopwatch_if #(.NUM_DIGITS(ND)) ifS ();

  assign ifW.startIn = startIn;
  assign ifW.clearIn = clearIn;
  assign ifW.lapIn   = lapIn;
  assign ifW.modeIn  = modeIn;
  assign ifS.startIn = startIn;
  assign ifS.clearIn = clearIn;
  assign ifS.lapIn   = lapIn;
  assign ifS.modeIn  = modeIn;

  bcd_lap_stopwatch #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .WRAP(1'b1), .PRESET(PRE))
    dutW (.clkIn(clkIn), .rstW(rstW), .sw(ifW));
  bcd_lap_stopwatch #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .WRAP(1'b0), .PRESET(PRE))
    dutS (.clkIn(clkIn), .rstW(rstW), .sw(ifS));

  // Reference model: the count is a plain integer (0..5999 in hundredths)
  int   nM [2], lapNM [2], phM [2];
  bit   runM [2], lapM [2], downM [2];
  bit   prevS, prevC, prevL, primedM;
  int   cyc;
  obs_t qW [$];
  obs_t qS [$];

  function automatic int p10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  task automatic modelReset();
    for (int u = 0; u < 2; u++) begin
      nM[u] = 0; lapNM[u] = 0; phM[u] = 0;
      runM[u] = 0; lapM[u] = 0; downM[u] = 0;
    end
    prevS = 0; prevC = 0; prevL = 0; primedM = 0; cyc = 0;
    qW.delete();
    qS.delete();
  endtask

  task automatic modelStep(input int u, input bit sEv, input bit cEv, input bit lEv);
    obs_t e;
    int   shown, k, nOld;
    bit   wrapOn;
    wrapOn = (u == 0);
    shown  = lapM[u] ? lapNM[u] : nM[u];
    k      = (cyc / SD) % ND;
    e.an   = ~(ND'(1) << k);
    e.seg  = SEG_TAB[(shown / p10(k)) % 10];
    e.done = 1'b0;
    nOld   = nM[u];
    if (runM[u]) begin
      if (phM[u] == TD - 1) begin
        phM[u] = 0;
        if (downM[u]) begin
          nM[u] = nM[u] - 1;
          if (nM[u] == 0) begin runM[u] = 0; e.done = 1'b1; end
        end else if (nM[u] == MODN - 1) begin
          e.done = 1'b1;
          if (wrapOn) nM[u] = 0;
          else runM[u] = 0;
        end else begin
          nM[u] = nM[u] + 1;
        end
      end else begin
        phM[u] = phM[u] + 1;
      end
      if (sEv) runM[u] = 0;
      if (lEv) begin
        if (!lapM[u]) lapNM[u] = nOld;
        lapM[u] = !lapM[u];
      end
    end else begin
      if (cEv) begin
        nM[u] = modeIn ? PREN : 0;
        phM[u] = 0;
        lapM[u] = 0;
      end
      if (lEv) lapM[u] = 0;
      if (sEv && !(modeIn && nM[u] == 0)) begin
        runM[u] = 1; downM[u] = modeIn; phM[u] = 0;
      end
    end
    e.run = runM[u];
    e.lap = lapM[u];
    if (u == 0) qW.push_back(e);
    else qS.push_back(e);
  endtask

  initial begin
    bit sEv, cEv, lEv;
    modelReset();
    forever begin
      @(posedge clkIn or posedge rstW);
      if (rstW) begin
        modelReset();
      end else begin
        sEv = startIn && !prevS && primedM;
        cEv = clearIn && !prevC && primedM;
        lEv = lapIn   && !prevL && primedM;
        modelStep(0, sEv, cEv, lEv);
        modelStep(1, sEv, cEv, lEv);
        prevS = startIn; prevC = clearIn; prevL = lapIn;
        primedM = 1;
        cyc = cyc + 1;
      end
    end
  end

  task automatic checkUnit(input int u, input obs_t act);
    obs_t e;
    bit   have;
    have = 1'b0;
    if (rstW) begin
      e.an = '1; e.seg = 7'h7F; e.run = 1'b0; e.lap = 1'b0; e.done = 1'b0;
      have = 1'b1;
    end else if (u == 0 && qW.size() > 0) begin
      e = qW.pop_front(); have = 1'b1;
    end else if (u == 1 && qS.size() > 0) begin
      e = qS.pop_front(); have = 1'b1;
    end
    if (have) begin
      compared++;
      if (act !== e) begin
        mismatched++;
        $display("FAIL %s t=%0t got an=%h seg=%h run=%b lap=%b done=%b want an=%h seg=%h run=%b lap=%b done=%b",
                 (u == 0) ? "wrapUnit" : "satUnit", $time, act.an, act.seg, act.run, act.lap, act.done,
                 e.an, e.seg, e.run, e.lap, e.done);
      end
    end
  endtask

  initial begin
    obs_t a;
    forever begin
      @(negedge clkIn);
      a = '{an: ifW.anOut, seg: ifW.segOut, run: ifW.runningOut, lap: ifW.lapOut, done: ifW.doneOut};
      checkUnit(0, a);
      a = '{an: ifS.anOut, seg: ifS.segOut, run: ifS.runningOut, lap: ifS.lapOut, done: ifS.doneOut};
      checkUnit(1, a);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clkIn);
    #1;
  endtask

  task automatic hit(input int which);
    case (which)
      0:       startIn = 1'b1;
      1:       clearIn = 1'b1;
      default: lapIn   = 1'b1;
    endcase
    step(1);
    startIn = 1'b0; clearIn = 1'b0; lapIn = 1'b0;
    step(1);
  endtask

  initial begin
    rstW = 1'b1;
    startIn = 1'b1; clearIn = 1'b0; lapIn = 1'b0; modeIn = 1'b0;
    step(3);
    rstW = 1'b0;
    step(6);
    startIn = 1'b0;
    step(3);

    // Count up through 59:99 -> wrap (wrapUnit) / saturate (satUnit)
    hit(0);
    for (int i = 0; i < 24400; i++) begin
      if ($urandom_range(0, 399) == 0) hit(2);
      else if ($urandom_range(0, 599) == 0) hit(1);
      else begin
        if ($urandom_range(0, 299) == 0) modeIn = ~modeIn;
        step(1);
      end
    end
    modeIn = 1'b0;
    step(2);

    // Stop, then count down from the preset to zero
    hit(0);
    step(10);
    if (lapIn == 1'b0) hit(2);
    modeIn = 1'b1;
    step(2);
    hit(1);
    hit(0);
    step(20);
    hit(0);
    step(10);

    // Random pressing of every control
    for (int i = 0; i < 3000; i++) begin
      startIn = ($urandom_range(0, 19) == 0);
      clearIn = ($urandom_range(0, 24) == 0);
      lapIn   = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 39) == 0) modeIn = ~modeIn;
      step(1);
    end
    startIn = 1'b0; clearIn = 1'b0; lapIn = 1'b0; modeIn = 1'b0;
    step(3);

    // Asynchronous reset mid-tick with start held through release
    hit(1);
    hit(0);
    step(125);
    @(posedge clkIn);
    #3 rstW = 1'b1;
    startIn = 1'b1;
    step(3);
    rstW = 1'b0;
    step(8);
    startIn = 1'b0;
    step(4);
    hit(0);
    step(200);

    @(negedge clkIn);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
